// File: rtl/gdo_stream_unit.sv
// Handshaked signed fixed-point operator unit: add/sub/mult/div/sigmoid/tanh/binary/pass
// with saturating results and an iterative restoring divider.
module gdo_stream_unit #(
  parameter int unsigned DATA_W = 17,
  parameter int unsigned FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic              out_dz
);

  localparam int unsigned W2     = 2 * DATA_W;
  localparam int unsigned Q_W    = DATA_W + FRAC_W;
  localparam int unsigned R_W    = DATA_W + 1;
  localparam int unsigned CNT_W  = $clog2(Q_W + 1);
  localparam int unsigned ONE    = 1 << FRAC_W;
  localparam int unsigned BP_HI  = 5 << FRAC_W;
  localparam int unsigned BP_MID = (19 << FRAC_W) >> 3;
  localparam int unsigned C_HI   = (27 << FRAC_W) >> 5;
  localparam int unsigned C_MID  = (5 << FRAC_W) >> 3;
  localparam int unsigned C_LO   = ONE >> 1;

  localparam logic [DATA_W-1:0]        ONE_D = DATA_W'(ONE);
  localparam logic signed [DATA_W-1:0] MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_D = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [W2-1:0]     MAX_W = {{(W2-DATA_W){1'b0}}, MAX_D};
  localparam logic signed [W2-1:0]     MIN_W = {{(W2-DATA_W){1'b1}}, MIN_D};

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MULT = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_SIG  = 3'd4;
  localparam logic [2:0] OP_TANH = 3'd5;
  localparam logic [2:0] OP_BIN  = 3'd6;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  // Returns {sat, value} after clamping a wide signed value to the data range.
  function automatic logic [DATA_W:0] sat_fn(input logic signed [W2-1:0] v);
    if (v > MAX_W)      return {1'b1, MAX_D};
    else if (v < MIN_W) return {1'b1, MIN_D};
    else                return {1'b0, v[DATA_W-1:0]};
  endfunction

  function automatic logic [DATA_W-1:0] abs_fn(input logic signed [DATA_W-1:0] x);
    return x[DATA_W-1] ? DATA_W'(-x) : x;
  endfunction

  function automatic logic [DATA_W-1:0] sigmoid_fn(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] m;
    logic [DATA_W-1:0] y;
    m = (x == MIN_D) ? MAX_D : abs_fn(x);
    if (m >= DATA_W'(BP_HI))       y = ONE_D;
    else if (m >= DATA_W'(BP_MID)) y = (m >> 5) + DATA_W'(C_HI);
    else if (m >= ONE_D)           y = (m >> 3) + DATA_W'(C_MID);
    else                           y = (m >> 2) + DATA_W'(C_LO);
    if (x[DATA_W-1]) y = ONE_D - y;
    return y;
  endfunction

  state_t                     state, state_next;
  logic [2:0]                 op_q, op_next;
  logic signed [DATA_W-1:0]   a_q, a_next, b_q, b_next;
  logic [Q_W-1:0]             dvd, dvd_next;
  logic [DATA_W-1:0]          rem, rem_next, dvs, dvs_next;
  logic [CNT_W-1:0]           cnt, cnt_next;
  logic [DATA_W-1:0]          data_next;
  logic                       sat_next, dz_next;
  logic                       accept;
  logic [R_W-1:0]             rem_sh, rem_sub;
  logic signed [W2-1:0]       qv, div_v, prod;
  logic [DATA_W:0]            alu_res, div_res, tanh_x2;
  logic [DATA_W-1:0]          tanh_s;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  // Single-cycle operators on the latched operands.
  always_comb begin
    alu_res = {1'b0, a_q};
    prod    = W2'(a_q) * W2'(b_q);
    tanh_x2 = sat_fn(W2'(a_q) <<< 1);
    tanh_s  = sigmoid_fn(tanh_x2[DATA_W-1:0]);
    case (op_q)
      OP_ADD:  alu_res = sat_fn(W2'(a_q) + W2'(b_q));
      OP_SUB:  alu_res = sat_fn(W2'(a_q) - W2'(b_q));
      OP_MULT: alu_res = sat_fn(prod >>> FRAC_W);
      OP_SIG:  alu_res = {1'b0, sigmoid_fn(a_q)};
      OP_TANH: alu_res = {tanh_x2[DATA_W], (tanh_s << 1) - ONE_D};
      OP_BIN:  alu_res = {1'b0, a_q[DATA_W-1] ? '0 : ONE_D};
      default: alu_res = {1'b0, a_q};
    endcase
  end

  // Restoring divide step and final sign-fix of the magnitude quotient.
  always_comb begin
    rem_sh  = {rem, dvd[Q_W-1]};
    rem_sub = rem_sh - {1'b0, dvs};
    qv      = {{(W2-Q_W){1'b0}}, dvd};
    div_v   = (a_q[DATA_W-1] ^ b_q[DATA_W-1]) ? -qv : qv;
    div_res = sat_fn(div_v);
  end

  always_comb begin
    state_next = state;
    op_next    = op_q;
    a_next     = a_q;
    b_next     = b_q;
    dvd_next   = dvd;
    rem_next   = rem;
    dvs_next   = dvs;
    cnt_next   = cnt;
    data_next  = out_data;
    sat_next   = out_sat;
    dz_next    = out_dz;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_next = EXEC;
          op_next    = in_op;
          a_next     = in_a;
          b_next     = in_b;
          dvd_next   = {abs_fn(in_a), {FRAC_W{1'b0}}};
          rem_next   = '0;
          dvs_next   = abs_fn(in_b);
          cnt_next   = '0;
        end else if (state == DONE && out_ready) begin
          state_next = IDLE;
        end
      end
      EXEC: begin
        if (op_q != OP_DIV) begin
          {sat_next, data_next} = alu_res;
          dz_next    = 1'b0;
          state_next = DONE;
        end else if (b_q == '0) begin
          data_next  = a_q[DATA_W-1] ? MIN_D : MAX_D;
          sat_next   = 1'b1;
          dz_next    = 1'b1;
          state_next = DONE;
        end else if (cnt == CNT_W'(Q_W)) begin
          {sat_next, data_next} = div_res;
          dz_next    = 1'b0;
          state_next = DONE;
        end else begin
          if (rem_sh >= {1'b0, dvs}) begin
            rem_next = DATA_W'(rem_sub);
            dvd_next = {dvd[Q_W-2:0], 1'b1};
          end else begin
            rem_next = DATA_W'(rem_sh);
            dvd_next = {dvd[Q_W-2:0], 1'b0};
          end
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dvd      <= '0;
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
      out_dz   <= 1'b0;
    end else begin
      state    <= state_next;
      op_q     <= op_next;
      a_q      <= a_next;
      b_q      <= b_next;
      dvd      <= dvd_next;
      rem      <= rem_next;
      dvs      <= dvs_next;
      cnt      <= cnt_next;
      out_data <= data_next;
      out_sat  <= sat_next;
      out_dz   <= dz_next;
    end
  end

endmodule

// File: tb/tb_gdo_stream_unit.sv
// Directed bench for gdo_stream_unit at DATA_W=17, FRAC_W=8 (ONE=256).
module tb_gdo_stream_unit;

  localparam int unsigned DW = 17;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sat;
  logic          out_dz;

  int checks = 0;
  int errors = 0;

  gdo_stream_unit #(.DATA_W(17), .FRAC_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_dz    (out_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] d(input int v);
    return DW'(v);
  endfunction

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op with out_ready high, measure edges to out_valid, check the result.
  task automatic run_op(input string tag, input logic [2:0] op, input int a, input int b,
                        input int exp, input int esat, input int edz, input int elat);
    int lat;
    int busy_rdy;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = d(a); in_b = d(b);
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 3'd7; in_a = d(-1); in_b = d(-1);
    lat = 0;
    busy_rdy = int'(in_ready);
    do begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid && in_ready) busy_rdy = 1;
    end while (!out_valid && lat < 60);
    chk_i({tag, " latency"}, lat, elat);
    chk_i({tag, " in_ready_busy"}, busy_rdy, 0);
    chk_d({tag, " data"}, out_data, d(exp));
    chk_i({tag, " sat"}, int'(out_sat), esat);
    chk_i({tag, " dz"}, int'(out_dz), edz);
    @(posedge clk); #1;
  endtask

  initial begin
    int stale;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #12;
    chk_i("reset in_ready", int'(in_ready), 1);
    chk_i("reset out_valid", int'(out_valid), 0);
    chk_d("reset data", out_data, d(0));
    chk_i("reset sat", int'(out_sat), 0);
    chk_i("reset dz", int'(out_dz), 0);
    @(negedge clk); rst_n = 1'b1;

    run_op("add", 3'd0, 16, 16, 32, 0, 0, 1);
    run_op("add_sat", 3'd0, 65535, 256, 65535, 1, 0, 1);
    run_op("sub", 3'd1, 768, 1280, -512, 0, 0, 1);
    run_op("mult", 3'd2, -128, 128, -64, 0, 0, 1);
    run_op("mult_sat", 3'd2, 32767, 32767, 65535, 1, 0, 1);
    run_op("div", 3'd3, 768, 256, 768, 0, 0, 26);
    run_op("div_neg", 3'd3, -768, 512, -384, 0, 0, 26);
    run_op("div_zero", 3'd3, 256, 0, 65535, 1, 1, 1);
    run_op("sig_0", 3'd4, 0, 0, 128, 0, 0, 1);
    run_op("sig_768", 3'd4, 768, 0, 240, 0, 0, 1);
    run_op("sig_m768", 3'd4, -768, 0, 16, 0, 0, 1);
    run_op("sig_2000", 3'd4, 2000, 0, 256, 0, 0, 1);
    run_op("tanh_256", 3'd5, 256, 0, 192, 0, 0, 1);
    run_op("bin_m1", 3'd6, -1, 0, 0, 0, 0, 1);
    run_op("bin_0", 3'd6, 0, 0, 256, 0, 0, 1);
    run_op("pass", 3'd7, -5, 99, -5, 0, 0, 1);

    // Backpressure then a same-edge accept.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd2; in_a = d(-128); in_b = d(128);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = d(7); in_b = d(7);
    @(posedge clk); #1;
    chk_i("bp valid", int'(out_valid), 1);
    chk_d("bp data", out_data, d(-64));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_i("bp hold valid", int'(out_valid), 1);
      chk_d("bp hold data", out_data, d(-64));
      chk_i("bp hold sat", int'(out_sat), 0);
      chk_i("bp hold in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_a = d(65535); in_b = d(256);
    #1;
    chk_i("bp ready low", int'(in_ready), 0);
    out_ready = 1'b1;
    #1;
    chk_i("bp ready follows", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_i("b2b exec valid", int'(out_valid), 0);
    chk_i("b2b exec in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    chk_i("b2b valid", int'(out_valid), 1);
    chk_d("b2b data", out_data, d(65535));
    chk_i("b2b sat", int'(out_sat), 1);
    @(posedge clk); #1;
    chk_i("b2b idle", int'(out_valid), 0);

    // Reset in the middle of a divide.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd3; in_a = d(768); in_b = d(256);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_i("midrst valid", int'(out_valid), 0);
    chk_i("midrst in_ready", int'(in_ready), 1);
    chk_d("midrst data", out_data, d(0));
    chk_i("midrst sat", int'(out_sat), 0);
    chk_i("midrst dz", int'(out_dz), 0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post_rst add", 3'd0, 1, 1, 2, 0, 0, 1);
    stale = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1;
    end
    chk_i("no stale div", stale, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gdo_stream_unit.md
# gdo_stream_unit

Parametrised, handshaked fixed-point operator unit for the neural datapath. It executes one gdo-style operation per transaction on signed Q-format operands: add, sub, mult, div, sigmoid, tanh, binary or pass. Operand width and fraction width are generic. Results saturate, and divide is iterative and multi-cycle. It sits between the layer sequencer, which issues operations, and the accumulator/activation writeback path.

## Interface
- DATA_W, default 17: operand/result width, signed two's complement.
- FRAC_W, default 8: fraction bits; ONE = 1<<FRAC_W, MAX = 2^(DATA_W-1)-1, MIN = -2^(DATA_W-1).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; in_ready = (state==IDLE) | (state==DONE & out_ready).
- in_op  in  3  0 ADD, 1 SUB, 2 MULT, 3 DIV, 4 SIGMOID, 5 TANH, 6 BINARY, 7 PASS (returns a).
- in_a, in_b  in  DATA_W  operands (b ignored by unary ops).
- out_valid  out  1  result held until accepted.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  result.
- out_sat  out  1  result was clamped to MAX/MIN.
- out_dz  out  1  DIV with b==0.

## Operation
- FSM states: IDLE, EXEC, DONE. Accept = in_valid & in_ready, which latches op/a/b and moves to EXEC.
- EXEC, non-DIV: single cycle; the result is registered and the FSM moves to DONE.
- EXEC, DIV: |a|<<FRAC_W (DATA_W+FRAC_W bits) divided by |b| using restoring division, one quotient bit per cycle for DATA_W+FRAC_W cycles, then a sign-fix/saturate cycle, then DONE. The quotient truncates toward zero.
- DIV with b==0: one EXEC cycle; result is MAX if a>=0, else MIN; out_dz=1 and out_sat=1.
- DONE: out_valid=1. While out_ready=0, out_data/out_sat/out_dz are held stable.
- On out_ready=1 the FSM goes to IDLE, or back to EXEC if a new accept happens on the same edge (back-to-back).
- ADD/SUB: computed at DATA_W+1 bits, then saturated.
- MULT: full 2*DATA_W product, arithmetic shift right by FRAC_W (floor), then saturated.
- SIGMOID: PLAN approximation on m=|x|, where |MIN| clamps to MAX.
  - m>=5.0: y=ONE.
  - m>=2.375: y=(m>>5)+0.84375.
  - m>=1.0: y=(m>>3)+0.625.
  - else y=(m>>2)+0.5.
  - Breakpoints and constants are rounded down to the Q grid.
  - If x<0, y=ONE-y.
- TANH: s = sigmoid(sat(2x)); y = 2s - ONE.
- BINARY: ONE if x>=0, else 0.
- out_sat is set only on ADD/SUB/MULT/DIV/TANH clamps; it is never set for SIGMOID or BINARY.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, out_sat=0, out_dz=0. Reset takes effect immediately, including mid-DIV; any in-flight transaction is dropped.
- Non-DIV latency: out_valid rises on the 1st edge after the accept edge.
- DIV latency: out_valid rises on edge DATA_W+FRAC_W+1 after accept (26 at defaults). DIV by zero: 1st edge.
- in_ready is low throughout EXEC. In DONE, in_ready combinationally follows out_ready.
- Peak throughput for non-DIV ops is one result per 2 cycles, sustained when out_ready stays high.
- in_a/in_b/in_op may change freely after the accept edge; the latched copies are used.
- out_valid falls on the edge where out_ready=1, unless a back-to-back accept keeps the unit busy (out_valid then low during EXEC).

## Test plan
- ADD 16+16 -> 32, sat=0. ADD 65535+256 -> 65535, sat=1. SUB 768-1280 -> -512. All with out_valid one edge after accept.
- MULT -128*128 -> -64. MULT 32767*32767 -> 65535, sat=1.
- DIV 768/256 -> 768, with out_valid exactly 26 edges after accept and in_ready low the whole time. DIV -768/512 -> -384. DIV 256/0 -> 65535 with dz=1, sat=1, 1-edge latency.
- SIGMOID 0 -> 128. SIGMOID 768 -> 240. SIGMOID -768 -> 16. SIGMOID 2000 -> 256. TANH 256 -> 192. BINARY -1 -> 0. BINARY 0 -> 256.
- Backpressure: hold out_ready=0 for 5 cycles after a MULT. Outputs stay stable and in_ready=0. Then assert out_ready with in_valid=1: the next op is accepted on the same edge and its result appears one edge later.
- Drop rst_n mid-DIV (cycle 10): outputs return to reset values immediately. After release, a new ADD 1+1 -> 2 completes normally with no stale DIV result.
